// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter requester front end.
package arb_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } chan_st_e;

  typedef struct packed {
    logic job_ready;
    logic req;
    logic beat;
    logic done;
    logic starve_err;
    logic spurious_err;
  } chan_rsp_t;

  function automatic int starve_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: job FSM, remaining-beat counter, starvation counter
// and the channel's sticky error flags.
module arb_req_chan
  import arb_pkg::*;
#(
  parameter int LEN_W        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  input  logic             gnt,
  input  logic             err_clr,
  output chan_rsp_t        rsp
);

  localparam int SW = starve_w(STARVE_LIMIT);
  localparam logic [LEN_W:0] R_ONE = (LEN_W+1)'(1);
  localparam logic [SW-1:0]  S_ONE = SW'(1);
  localparam logic [SW-1:0]  S_LIM = SW'(STARVE_LIMIT);

  chan_st_e       st, st_nxt;
  logic [LEN_W:0] rem, rem_nxt;
  logic [SW-1:0]  scnt, scnt_nxt;
  logic           starve_q, spur_q;
  logic           req, beat, waiting, starve_set, spur_set;

  assign req        = (st == ST_REQ);
  assign beat       = req & gnt;
  assign waiting    = req & ~gnt;
  assign spur_set   = gnt & ~req;
  // Re-fires while saturated so a concurrent err_clr cannot hide ongoing starvation
  assign starve_set = waiting && (scnt_nxt == S_LIM);

  always_comb begin
    st_nxt  = st;
    rem_nxt = rem;
    case (st)
      ST_IDLE: if (job_valid) begin
        rem_nxt = {1'b0, job_len} + R_ONE;
        st_nxt  = ST_REQ;
      end
      ST_REQ: if (gnt) begin
        rem_nxt = rem - R_ONE;
        if (rem == R_ONE) st_nxt = ST_GAP;
      end
      ST_GAP:  st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    scnt_nxt = '0;
    if (waiting) scnt_nxt = (scnt == S_LIM) ? scnt : scnt + S_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      rem      <= '0;
      scnt     <= '0;
      starve_q <= 1'b0;
      spur_q   <= 1'b0;
    end else begin
      st       <= st_nxt;
      rem      <= rem_nxt;
      scnt     <= scnt_nxt;
      starve_q <= starve_set | (starve_q & ~err_clr);
      spur_q   <= spur_set | (spur_q & ~err_clr);
    end
  end

  assign rsp.job_ready    = (st == ST_IDLE);
  assign rsp.req          = req;
  assign rsp.beat         = beat;
  assign rsp.done         = (st == ST_GAP);
  assign rsp.starve_err   = starve_q;
  assign rsp.spurious_err = spur_q;

endmodule

// File: rtl/rr_arb_requester.sv
// Requester-side front end for the N-way round-robin arbiter: per-channel
// job FSMs plus the shared multi-grant check.
module rr_arb_requester
  import arb_pkg::*;
#(
  parameter int N            = N_DEF,
  parameter int LEN_W        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       job_valid,
  input  logic [N*LEN_W-1:0] job_len,
  output logic [N-1:0]       job_ready,
  output logic [N-1:0]       REQ,
  input  logic [N-1:0]       GNT,
  output logic [N-1:0]       beat,
  output logic [N-1:0]       done,
  input  logic               err_clr,
  output logic [N-1:0]       starve_err,
  output logic [N-1:0]       spurious_err,
  output logic               onehot_err
);

  localparam logic [N-1:0] G_ONE = N'(1);

  chan_rsp_t rsp [N];
  logic      multi_gnt;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    arb_req_chan #(
      .LEN_W       (LEN_W),
      .STARVE_LIMIT(STARVE_LIMIT)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .job_valid(job_valid[gi]),
      .job_len  (job_len[gi*LEN_W +: LEN_W]),
      .gnt      (GNT[gi]),
      .err_clr  (err_clr),
      .rsp      (rsp[gi])
    );
    assign job_ready[gi]    = rsp[gi].job_ready;
    assign REQ[gi]          = rsp[gi].req;
    assign beat[gi]         = rsp[gi].beat;
    assign done[gi]         = rsp[gi].done;
    assign starve_err[gi]   = rsp[gi].starve_err;
    assign spurious_err[gi] = rsp[gi].spurious_err;
  end

  // Clearing the lowest set bit leaves something only if two or more were set
  assign multi_gnt = |(GNT & (GNT - G_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) onehot_err <= 1'b0;
    else        onehot_err <= multi_gnt | (onehot_err & ~err_clr);
  end

endmodule

// File: tb/tb_rr_arb_requester.sv
// Bench for rr_arb_requester: directed and random cycles scored against a
// beats-remaining reference model through an expectation queue.
module tb_rr_arb_requester;
  localparam int N = 4, LEN_W = 4, LIM = 16;

  logic               clk = 0, rst_n = 0, err_clr = 0;
  logic [N-1:0]       job_valid = '0, GNT = '0;
  logic [N*LEN_W-1:0] job_len = '0;
  logic [N-1:0]       job_ready, REQ, beat, done, starve_err, spurious_err;
  logic               onehot_err;

  rr_arb_requester #(.N(N), .LEN_W(LEN_W), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_len(job_len),
    .job_ready(job_ready), .REQ(REQ), .GNT(GNT), .beat(beat), .done(done),
    .err_clr(err_clr), .starve_err(starve_err), .spurious_err(spurious_err),
    .onehot_err(onehot_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req, ready, done, beat, starve, spur;
    logic         onehot;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;

  // Reference model: beats still owed per channel, post-job gap, waiting time
  int           left[N], waited[N];
  logic [N-1:0] gap_m, starve_m, spur_m;
  logic         onehot_m;
  int           rr_last = N - 1;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin left[i] = 0; waited[i] = 0; end
    gap_m = '0; starve_m = '0; spur_m = '0; onehot_m = 0;
  endfunction

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("REQ", REQ, e.req);
      chk("job_ready", job_ready, e.ready);
      chk("done", done, e.done);
      chk("beat", beat, e.beat);
      chk("starve_err", starve_err, e.starve);
      chk("spurious_err", spurious_err, e.spur);
      chk("onehot_err", {3'b000, onehot_err}, {3'b000, e.onehot});
    end
  end

  task automatic cyc(input logic [N-1:0] jv, input logic [N*LEN_W-1:0] jl,
                     input logic [N-1:0] g_in, input logic clr, input logic rst,
                     input bit use_rr);
    logic [N-1:0] req_m, sv_s, g;
    exp_t e;
    bit found;
    @(posedge clk); #1;
    rst_n = rst;
    if (!rst) model_reset();
    for (int i = 0; i < N; i++) req_m[i] = (left[i] > 0);
    g = g_in;
    if (use_rr) begin
      g = '0; found = 0;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (rr_last + k) % N;
        if (!found && req_m[idx]) begin g[idx] = 1'b1; rr_last = idx; found = 1; end
      end
    end
    job_valid = jv; job_len = jl; GNT = g; err_clr = clr;
    e.req = req_m; e.done = gap_m; e.ready = ~req_m & ~gap_m; e.beat = req_m & g;
    e.starve = starve_m; e.spur = spur_m; e.onehot = onehot_m;
    q.push_back(e);
    if (rst) begin
      sv_s = '0;
      for (int i = 0; i < N; i++) begin
        if (gap_m[i]) gap_m[i] = 0;
        else if (left[i] > 0) begin
          if (g[i]) begin
            left[i]--; waited[i] = 0;
            if (left[i] == 0) gap_m[i] = 1;
          end else begin
            if (waited[i] < LIM) waited[i]++;
            if (waited[i] >= LIM) sv_s[i] = 1;
          end
        end else begin
          waited[i] = 0;
          if (jv[i]) left[i] = int'(jl[i*LEN_W +: LEN_W]) + 1;
        end
      end
      if (clr) begin starve_m = '0; spur_m = '0; onehot_m = 0; end
      starve_m |= sv_s;
      spur_m   |= g & ~req_m;
      onehot_m |= ($countones(g) > 1);
    end
  endtask

  initial begin
    logic [5:0] pat;
    model_reset();
    repeat (3) cyc('0, '0, '0, 0, 0, 0);
    // single channel, three back-to-back beats
    cyc(4'b0001, 16'h0002, '0, 0, 1, 0);
    repeat (3) cyc('0, '0, 4'b0001, 0, 1, 0);
    repeat (3) cyc('0, '0, '0, 0, 1, 0);
    // all channels one beat each under round-robin grants
    cyc(4'b1111, 16'h0000, '0, 0, 1, 0);
    repeat (10) cyc('0, '0, '0, 0, 1, 1);
    // grants with waits in between
    cyc(4'b0010, 16'h0030, '0, 0, 1, 0);
    pat = 6'b111001;
    for (int k = 0; k < 6; k++) cyc('0, '0, pat[k] ? 4'b0010 : 4'b0000, 0, 1, 0);
    repeat (3) cyc('0, '0, '0, 0, 1, 0);
    // starvation at the limit, flag holds, then cleared
    cyc(4'b0100, 16'h0000, '0, 0, 1, 0);
    repeat (LIM) cyc('0, '0, '0, 0, 1, 0);
    cyc('0, '0, 4'b0100, 0, 1, 0);
    repeat (2) cyc('0, '0, '0, 0, 1, 0);
    cyc('0, '0, '0, 1, 1, 0);
    repeat (2) cyc('0, '0, '0, 0, 1, 0);
    // spurious grant on idle channel, then a multi-hot grant
    cyc('0, '0, 4'b1000, 0, 1, 0);
    cyc(4'b0011, 16'h0033, '0, 0, 1, 0);
    cyc('0, '0, 4'b0011, 0, 1, 0);
    repeat (10) cyc('0, '0, '0, 0, 1, 1);
    cyc('0, '0, '0, 1, 1, 0);
    // reset in the middle of a job, then a fresh job
    cyc(4'b0001, 16'h0007, '0, 0, 1, 0);
    repeat (3) cyc('0, '0, 4'b0001, 0, 1, 0);
    cyc('0, '0, '0, 0, 0, 0);
    cyc('0, '0, '0, 0, 1, 0);
    cyc(4'b0001, 16'h0005, '0, 0, 1, 0);
    repeat (8) cyc('0, '0, '0, 0, 1, 1);
    // random traffic
    for (int c = 0; c < 2500; c++) begin
      int m;
      logic [N-1:0] jv, g;
      logic [N*LEN_W-1:0] jl;
      bit rr, clr, rst;
      jv  = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      jl  = (N*LEN_W)'($urandom);
      m   = $urandom_range(0, 99);
      rr  = (m < 70);
      g   = (m >= 70 && m < 82) ? N'($urandom) : '0;
      clr = ($urandom_range(0, 99) < 4);
      rst = ($urandom_range(0, 299) != 0);
      cyc(jv, jl, g, clr, rst, rr);
    end
    repeat (4) cyc('0, '0, '0, 0, 1, 1);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain actual=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
